// File: rtl/penc_pending_16to4_pkg.sv
// Shared constants, state encoding and helpers for the pending-request tracker.
package penc_pending_16to4_pkg;

  localparam int N_SRC = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [N_SRC-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_SRC-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/penc_pending_16to4_lo.sv
// Combinational 16-to-4 priority encoder; the lowest set bit wins.
module penc_16to4_lo
  import penc_pending_16to4_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    any = |req;
    // Scan downward so the last assignment is the lowest index.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = i[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/penc_pending_16to4.sv
// Sticky pending-request tracker presenting the lowest enabled pending source
// on a registered valid/ready output; re-requests while pending flag overflow.
module penc_pending_16to4
  import penc_pending_16to4_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] set_,
  input  logic [N_SRC-1:0] mask,
  input  logic             clr_ovf,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [IDX_W-1:0] out_idx,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] ovf,
  output state_t           state
);

  // Handshake: out_idx transfers on any edge where out_val && out_rdy.
  // While out_val is high, out_idx does not change until that transfer.
  logic             hs;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] cand;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;

  assign out_val = (state == HOLD);
  assign hs      = out_val & out_rdy;
  assign clr     = hs ? onehot(out_idx) : '0;
  assign cand    = pending & mask & ~clr;

  penc_16to4_lo u_enc (
    .req (cand),
    .idx (sel_idx),
    .any (sel_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      out_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_any) begin
            state   <= HOLD;
            out_idx <= sel_idx;
          end
        end
        HOLD: begin
          // Held index is never preempted; only a handshake moves it.
          if (hs) begin
            if (sel_any) begin
              out_idx <= sel_idx;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      ovf     <= '0;
    end else begin
      pending <= set_ | (pending & ~clr);
      // The overflow term is ORed after the clear so a same-cycle event survives.
      ovf     <= (clr_ovf ? '0 : ovf) | (set_ & pending & ~clr);
    end
  end

endmodule
